// File: rtl/branch_predict_unit_if.sv
// Fetch-prediction and branch-resolution signal bundle for branch_predict_unit.
// The master side drives PCs and resolution inputs; the slave side is the predictor.
interface branch_predict_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            ready;
  logic            res_valid;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [2:0]      funct3;
  logic            branch_enable;
  logic            jump;
  logic            pred_was_taken;
  logic            branch_taken;
  logic            mispredict;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output pred_pc, res_valid, res_pc, rs1_data, rs2_data, funct3,
           branch_enable, jump, pred_was_taken,
    input  pred_taken, ready, branch_taken, mispredict,
           branch_count, mispredict_count
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, rs1_data, rs2_data, funct3,
           branch_enable, jump, pred_was_taken,
    output pred_taken, ready, branch_taken, mispredict,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// with after-reset init sweep, branch resolution, mispredict pulse and statistics.
module branch_predict_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input logic                 clk,
  input logic                 rst,
  branch_predict_unit_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             ready_q, ready_d;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      bcnt_q, bcnt_d;
  logic [31:0]      mcnt_q, mcnt_d;

  logic [1:0]       bht [BHT_DEPTH];

  logic [XLEN-1:0]  rs1, rs2;
  logic [IDX_W-1:0] pred_idx, res_idx;
  logic             eq, lt_s, lt_u;
  logic             valid_br, taken, update;
  logic [1:0]       ctr_cur, ctr_next;

  assign rs1      = bus.rs1_data;
  assign rs2      = bus.rs2_data;
  assign pred_idx = bus.pred_pc[IDX_W+1:2];
  assign res_idx  = bus.res_pc[IDX_W+1:2];

  // Reads see the table before this cycle's update lands.
  assign bus.pred_taken       = ready_q & bht[pred_idx][1];
  assign bus.branch_taken     = taken;
  assign bus.ready            = ready_q;
  assign bus.mispredict       = mispredict_q;
  assign bus.branch_count     = bcnt_q;
  assign bus.mispredict_count = mcnt_q;

  always_comb begin
    eq       = (rs1 == rs2);
    lt_s     = ($signed(rs1) < $signed(rs2));
    lt_u     = (rs1 < rs2);
    valid_br = bus.branch_enable &
               (bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111});
    taken    = 1'b0;
    if (bus.branch_enable) begin
      case (bus.funct3)
        3'b000:  taken = eq;
        3'b001:  taken = ~eq;
        3'b100:  taken = lt_s;
        3'b101:  taken = ~lt_s;
        3'b110:  taken = lt_u;
        3'b111:  taken = ~lt_u;
        default: taken = 1'b0;
      endcase
    end else if (bus.jump) begin
      taken = 1'b1;
    end

    update  = bus.res_valid & ready_q & valid_br;
    ctr_cur = bht[res_idx];
    if (taken) ctr_next = (ctr_cur == 2'b11) ? ctr_cur : ctr_cur + 2'd1;
    else       ctr_next = (ctr_cur == 2'b00) ? ctr_cur : ctr_cur - 2'd1;

    mispredict_d = bus.res_valid & ready_q &
                   (valid_br | (bus.jump & ~bus.branch_enable)) &
                   (taken != bus.pred_was_taken);

    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == IDX_W'(BHT_DEPTH - 1)) state_d = RUN;
    end
    ready_d = (state_d == RUN);

    bcnt_d = (update && bcnt_q != '1) ? bcnt_q + 32'd1 : bcnt_q;
    mcnt_d = (mispredict_d && mcnt_q != '1) ? mcnt_q + 32'd1 : mcnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      ready_q      <= 1'b0;
      mispredict_q <= 1'b0;
      bcnt_q       <= '0;
      mcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ready_q      <= ready_d;
      mispredict_q <= mispredict_d;
      bcnt_q       <= bcnt_d;
      mcnt_q       <= mcnt_d;
    end
  end

  // Table has no reset: contents are only defined once the sweep has run.
  always_ff @(posedge clk) begin
    if (state_q == INIT) bht[sweep_q] <= INIT_STATE;
    else if (update)     bht[res_idx] <= ctr_next;
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized self-checking bench for branch_predict_unit against a behavioural
// counter-table model.
module tb_branch_predict_unit;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_predict_unit_if #(.XLEN(32)) bus();

  branch_predict_unit #(
    .XLEN(32),
    .BHT_DEPTH(DEPTH),
    .INIT_STATE(2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          ctr_m [DEPTH];
  longint      bcnt_m, mcnt_m;
  bit          ready_m;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_taken(bit be, bit j, logic [2:0] f3,
                                   logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (be) begin
      case (f3)
        3'd0: return a == b;
        3'd1: return a != b;
        3'd4: return sa < sb;
        3'd5: return sa >= sb;
        3'd6: return a < b;
        3'd7: return a >= b;
        default: return 1'b0;
      endcase
    end
    return j;
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  task automatic drive(logic [31:0] ppc, bit rv, logic [31:0] rpc,
                       logic [31:0] a, logic [31:0] b, logic [2:0] f3,
                       bit be, bit j, bit pwt);
    bus.pred_pc        = ppc;
    bus.res_valid      = rv;
    bus.res_pc         = rpc;
    bus.rs1_data       = a;
    bus.rs2_data       = b;
    bus.funct3         = f3;
    bus.branch_enable  = be;
    bus.jump           = j;
    bus.pred_was_taken = pwt;
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  task automatic step();
    int pi, ri;
    bit bt, vb, upd, mp;
    #1;
    pi  = idx_of(bus.pred_pc);
    ri  = idx_of(bus.res_pc);
    bt  = ref_taken(bus.branch_enable, bus.jump, bus.funct3, bus.rs1_data, bus.rs2_data);
    vb  = bus.branch_enable && bus.funct3 != 3'd2 && bus.funct3 != 3'd3;
    upd = bus.res_valid && ready_m && vb;
    mp  = bus.res_valid && ready_m && (vb || (bus.jump && !bus.branch_enable)) &&
          (bt != bus.pred_was_taken);
    check("pred_taken", {63'd0, bus.pred_taken}, {63'd0, ready_m && ctr_m[pi] >= 2});
    check("branch_taken", {63'd0, bus.branch_taken}, {63'd0, bt});
    @(posedge clk);
    #1;
    if (upd) begin
      if (bt) ctr_m[ri] = (ctr_m[ri] >= 3) ? 3 : ctr_m[ri] + 1;
      else    ctr_m[ri] = (ctr_m[ri] <= 0) ? 0 : ctr_m[ri] - 1;
      if (bcnt_m < 64'hFFFF_FFFF) bcnt_m++;
    end
    if (mp && mcnt_m < 64'hFFFF_FFFF) mcnt_m++;
    check("mispredict", {63'd0, bus.mispredict}, {63'd0, mp});
    check("branch_count", {32'd0, bus.branch_count}, bcnt_m);
    check("mispredict_count", {32'd0, bus.mispredict_count}, mcnt_m);
    check("ready", {63'd0, bus.ready}, {63'd0, ready_m});
  endtask

  // Asserts reset, checks cleared outputs, then times the init sweep.
  // A nonzero abort_at returns that many cycles into the sweep.
  task automatic do_reset(int abort_at);
    int cyc;
    rst = 1'b1;
    bus.pred_pc = $urandom;
    ready_m = 1'b0;
    #1;
    check("rst_ready", {63'd0, bus.ready}, 64'd0);
    check("rst_mispredict", {63'd0, bus.mispredict}, 64'd0);
    check("rst_branch_count", {32'd0, bus.branch_count}, 64'd0);
    check("rst_mispredict_count", {32'd0, bus.mispredict_count}, 64'd0);
    check("rst_pred_taken", {63'd0, bus.pred_taken}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (abort_at != 0 && c == abort_at) begin
        check("midsweep_ready", {63'd0, bus.ready}, 64'd0);
        return;
      end
      if (bus.ready === 1'b1) begin
        cyc = c;
        break;
      end
      bus.pred_pc = $urandom;
      #1;
      check("init_pred_taken", {63'd0, bus.pred_taken}, 64'd0);
      #1;
    end
    check("init_cycles", 64'(cyc), 64'd64);
    for (int i = 0; i < int'(DEPTH); i++) ctr_m[i] = 1;
    bcnt_m  = 0;
    mcnt_m  = 0;
    ready_m = 1'b1;
  endtask

  task automatic random_steps(int n);
    logic [31:0] ppc, rpc, a, b;
    for (int i = 0; i < n; i++) begin
      ppc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15) * 4);
      rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) rpc = ppc;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 3));
        2:       b = ~a;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF;
      drive(ppc, $urandom_range(0, 9) < 7, rpc, a, b, 3'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      step();
    end
  endtask

  initial begin
    drive('0, 1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    ready_m = 1'b0;
    bcnt_m  = 0;
    mcnt_m  = 0;
    @(posedge clk);
    #1;
    do_reset(30);
    do_reset(0);

    for (int i = 0; i < 8; i++) begin
      drive($urandom, 1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
    end

    for (int i = 0; i < 4; i++) begin
      drive(32'h40, 1'b1, 32'h40, 32'd5, 32'd5, 3'd0, 1'b1, 1'b0, 1'($urandom));
      step();
    end
    drive(32'h40, 1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("beq_pred_after", {63'd0, bus.pred_taken}, 64'd1);
    check("beq_branch_count", {32'd0, bus.branch_count}, 64'd4);

    drive('0, 1'b1, 32'h44, 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b1, 1'b0, 1'b0);
    step();
    drive('0, 1'b1, 32'h44, 32'hFFFF_FFFF, 32'd1, 3'd6, 1'b1, 1'b0, 1'b0);
    step();

    drive(32'h48, 1'b1, 32'h48, 32'd1, 32'd1, 3'd2, 1'b1, 1'b0, 1'b1);
    step();
    drive(32'h48, 1'b1, 32'h48, 32'd1, 32'd2, 3'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(32'h48, 1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();

    drive(32'h80, 1'b1, 32'h80, 32'd7, 32'd7, 3'd0, 1'b1, 1'b0, 1'b1);
    step();
    drive(32'h80, 1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();

    random_steps(500);
    do_reset(0);
    random_steps(150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
